// File: rtl/imm_extract_pipe.sv
// imm_extract_pipe: RV immediate decoder feeding a DEPTH-entry FIFO.
// Ports: clk, reset (sync, active-low); in_valid/in_ready/instruction
//   input handshake; out_valid/out_ready/im_data/fmt head entry;
//   dec_count (accepted words, wraps), err_count (illegal, saturates).
module imm_extract_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] im_data,
  output logic [2:0]      fmt,
  output logic [15:0]     dec_count,
  output logic [7:0]      err_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef enum logic {
    EMPTY,
    NONEMPTY
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [15:0]     dec_q, dec_d;
  logic [7:0]      err_q, err_d;
  logic [XLEN-1:0] hold_imm_q, hold_imm_d;
  logic [2:0]      hold_fmt_q, hold_fmt_d;

  logic [XLEN-1:0] imm_mem_q [DEPTH];
  logic [2:0]      fmt_mem_q [DEPTH];

  logic [6:0]  opc;
  logic        s;
  logic [2:0]  fmt_dec;
  logic [63:0] imm64;
  logic        push;
  logic        pop;

  assign opc = instruction[6:0];
  assign s   = instruction[31];

  // Immediates are built at 64 bits and truncated, so one
  // decoder serves both XLEN settings.
  always_comb begin
    fmt_dec = FMT_ILL;
    imm64   = '0;
    unique case (1'b1)
      (opc == 7'b0000011),
      (opc == 7'b0010011),
      (opc == 7'b1100111),
      (RV64 && opc == 7'b0011011): begin
        fmt_dec = FMT_I;
        imm64   = {{52{s}}, instruction[31:20]};
      end
      (opc == 7'b0100011): begin
        fmt_dec = FMT_S;
        imm64   = {{52{s}}, instruction[31:25],
                   instruction[11:7]};
      end
      (opc == 7'b1100011): begin
        fmt_dec = FMT_B;
        imm64   = {{51{s}}, s, instruction[7],
                   instruction[30:25],
                   instruction[11:8], 1'b0};
      end
      (opc == 7'b0110111),
      (opc == 7'b0010111): begin
        fmt_dec = FMT_U;
        imm64   = {{32{s}}, instruction[31:12], 12'b0};
      end
      (opc == 7'b1101111): begin
        fmt_dec = FMT_J;
        imm64   = {{43{s}}, s, instruction[19:12],
                   instruction[20],
                   instruction[30:21], 1'b0};
      end
      (opc == 7'b0110011),
      (RV64 && opc == 7'b0111011): begin
        fmt_dec = FMT_R;
      end
      default: begin
        fmt_dec = FMT_ILL;
      end
    endcase
  end

  // Handshakes are gated by reset so nothing moves while held.
  assign in_ready  = reset && (count_q < DEPTH_C);
  assign out_valid = reset && (state_q == NONEMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: begin
        if (push) state_d = NONEMPTY;
      end
      NONEMPTY: begin
        if (pop && !push && count_q == ONE_C)
          state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    dec_d      = dec_q;
    err_d      = err_q;
    hold_imm_d = hold_imm_q;
    hold_fmt_d = hold_fmt_q;
    if (push) begin
      wptr_d = wptr_q + AW'(1);
      dec_d  = dec_q + 16'd1;
      if (fmt_dec == FMT_ILL && err_q != 8'hFF)
        err_d = err_q + 8'd1;
    end
    if (pop) begin
      rptr_d     = rptr_q + AW'(1);
      // Remember the retiring head so outputs hold once empty.
      hold_imm_d = imm_mem_q[rptr_q];
      hold_fmt_d = fmt_mem_q[rptr_q];
    end
    if (push && !pop)
      count_d = count_q + ONE_C;
    else if (pop && !push)
      count_d = count_q - ONE_C;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= EMPTY;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      dec_q      <= '0;
      err_q      <= '0;
      hold_imm_q <= '0;
      hold_fmt_q <= FMT_R;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
      hold_imm_q <= hold_imm_d;
      hold_fmt_q <= hold_fmt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem_q[wptr_q] <= imm64[XLEN-1:0];
      fmt_mem_q[wptr_q] <= fmt_dec;
    end
  end

  assign im_data = (state_q == NONEMPTY) ? imm_mem_q[rptr_q]
                                         : hold_imm_q;
  assign fmt     = (state_q == NONEMPTY) ? fmt_mem_q[rptr_q]
                                         : hold_fmt_q;

  assign dec_count = dec_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_imm_extract_pipe.sv
// tb_imm_extract_pipe: directed vectors for imm_extract_pipe,
// one XLEN=64 and one XLEN=32 instance on shared stimulus.
module tb_imm_extract_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instruction;
  logic        out_ready;

  logic        rdy64, vld64;
  logic [63:0] im64;
  logic [2:0]  fmt64;
  logic [15:0] dc64;
  logic [7:0]  ec64;

  logic        rdy32, vld32;
  logic [31:0] im32;
  logic [2:0]  fmt32;
  logic [15:0] dc32;
  logic [7:0]  ec32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_extract_pipe #(.XLEN(64), .DEPTH(2)) u64 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy64),
    .instruction(instruction),
    .out_valid(vld64), .out_ready(out_ready),
    .im_data(im64), .fmt(fmt64),
    .dec_count(dc64), .err_count(ec64)
  );

  imm_extract_pipe #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(rdy32),
    .instruction(instruction),
    .out_valid(vld32), .out_ready(out_ready),
    .im_data(im32), .fmt(fmt32),
    .dec_count(dc32), .err_count(ec32)
  );

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  f64;
    logic [63:0] i64;
    logic [2:0]  f32;
  } vec_t;

  localparam int NV = 19;
  vec_t v [NV];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic head64(input string nm,
                        input logic [2:0] f,
                        input logic [63:0] im);
    chk({nm, " vld"}, 64'(vld64), 64'd1);
    chk({nm, " fmt"}, 64'(fmt64), 64'(f));
    chk({nm, " imm"}, im64, im);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e32;
    int ne64, ne32;

    v[0]  = '{32'hFFF00093, 3'd1, 64'hFFFFFFFFFFFFFFFF, 3'd1};
    v[1]  = '{32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3};
    v[2]  = '{32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
    v[3]  = '{32'hFFE1FF00, 3'd7, 64'h0,                3'd7};
    v[4]  = '{32'h0020A423, 3'd2, 64'h8,                3'd2};
    v[5]  = '{32'hFE112E23, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2};
    v[6]  = '{32'h8000006F, 3'd5, 64'hFFFFFFFFFFF00000, 3'd5};
    v[7]  = '{32'h001000EF, 3'd5, 64'h800,              3'd5};
    v[8]  = '{32'h000FF06F, 3'd5, 64'hFF000,            3'd5};
    v[9]  = '{32'h12345017, 3'd4, 64'h12345000,         3'd4};
    v[10] = '{32'h00B50533, 3'd0, 64'h0,                3'd0};
    v[11] = '{32'h00B5053B, 3'd0, 64'h0,                3'd7};
    v[12] = '{32'h0010009B, 3'd1, 64'h1,                3'd7};
    v[13] = '{32'h80002083, 3'd1, 64'hFFFFFFFFFFFFF800, 3'd1};
    v[14] = '{32'h7FF08067, 3'd1, 64'h7FF,              3'd1};
    v[15] = '{32'h00000463, 3'd3, 64'h8,                3'd3};
    v[16] = '{32'h000000E3, 3'd3, 64'h800,              3'd3};
    v[17] = '{32'h0000001B, 3'd1, 64'h0,                3'd7};
    v[18] = '{32'h0000007F, 3'd7, 64'h0,                3'd7};

    reset       = 1'b0;
    in_valid    = 1'b0;
    instruction = 32'h0;
    out_ready   = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst rdy", 64'(rdy64), 64'd0);
    chk("rst vld", 64'(vld64), 64'd0);
    reset = 1'b1;
    #1;
    chk("rel rdy", 64'(rdy64), 64'd1);
    @(negedge clk);
    chk("rst2 rdy", 64'(rdy64), 64'd1);
    chk("rst2 vld", 64'(vld64), 64'd0);
    chk("rst imm", im64, 64'd0);
    chk("rst fmt", 64'(fmt64), 64'd0);
    chk("rst dec", 64'(dc64), 64'd0);
    chk("rst err", 64'(ec64), 64'd0);

    ne64 = 0;
    ne32 = 0;
    for (int i = 0; i < NV; i++) begin
      in_valid    = 1'b1;
      instruction = v[i].inst;
      out_ready   = 1'b0;
      if (v[i].f64 == 3'd7) ne64++;
      if (v[i].f32 == 3'd7) ne32++;
      e32 = (v[i].f32 == 3'd7) ? 32'h0 : v[i].i64[31:0];
      @(negedge clk);
      in_valid = 1'b0;
      head64($sformatf("v%0d", i), v[i].f64, v[i].i64);
      chk($sformatf("v%0d dec", i), 64'(dc64), 64'(i + 1));
      chk($sformatf("v%0d err", i), 64'(ec64), 64'(ne64));
      chk($sformatf("v%0d vld32", i), 64'(vld32), 64'd1);
      chk($sformatf("v%0d fmt32", i), 64'(fmt32),
          64'(v[i].f32));
      chk($sformatf("v%0d imm32", i), 64'(im32), 64'(e32));
      chk($sformatf("v%0d err32", i), 64'(ec32), 64'(ne32));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk($sformatf("v%0d empty", i), 64'(vld64), 64'd0);
      chk($sformatf("v%0d hold", i), im64, v[i].i64);
      chk($sformatf("v%0d holdf", i), 64'(fmt64),
          64'(v[i].f64));
    end

    // back-pressure: three pushes into a 2-deep buffer
    in_valid    = 1'b1;
    instruction = 32'h00100093;
    @(negedge clk);
    chk("bp rdy1", 64'(rdy64), 64'd1);
    instruction = 32'h00200093;
    @(negedge clk);
    chk("bp full", 64'(rdy64), 64'd0);
    instruction = 32'h00300093;
    @(negedge clk);
    chk("bp held rdy", 64'(rdy64), 64'd0);
    head64("bp hA", 3'd1, 64'd1);
    out_ready = 1'b1;
    #1;
    chk("bp full pop rdy", 64'(rdy64), 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp rdy2", 64'(rdy64), 64'd1);
    head64("bp hB", 3'd1, 64'd2);
    @(negedge clk);
    in_valid  = 1'b0;
    chk("bp full2", 64'(rdy64), 64'd0);
    head64("bp hB2", 3'd1, 64'd2);
    out_ready = 1'b1;
    @(negedge clk);
    head64("bp hC", 3'd1, 64'd3);
    @(negedge clk);
    chk("bp drained", 64'(vld64), 64'd0);

    // simultaneous push and pop at occupancy 1
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h00400093;
    @(negedge clk);
    out_ready   = 1'b1;
    instruction = 32'h00500093;
    @(negedge clk);
    head64("pp h5", 3'd1, 64'd5);
    chk("pp rdy", 64'(rdy64), 64'd1);
    instruction = 32'hFFB00093;
    @(negedge clk);
    in_valid = 1'b0;
    head64("pp hneg5", 3'd1, 64'hFFFFFFFFFFFFFFFB);
    @(negedge clk);
    chk("pp drained", 64'(vld64), 64'd0);

    // counters: fresh reset, then stream illegal words
    out_ready = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset       = 1'b1;
    in_valid    = 1'b1;
    out_ready   = 1'b1;
    instruction = 32'hFFE1FF00;
    repeat (300) @(negedge clk);
    chk("sat dec", 64'(dc64), 64'd300);
    chk("sat err", 64'(ec64), 64'hFF);
    chk("sat err32", 64'(ec32), 64'hFF);
    repeat (65536 - 300) @(negedge clk);
    in_valid = 1'b0;
    chk("wrap dec", 64'(dc64), 64'd0);
    chk("wrap err", 64'(ec64), 64'hFF);
    @(negedge clk);
    chk("wrap drained", 64'(vld64), 64'd0);

    // reset with two entries buffered
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    instruction = 32'h00100093;
    repeat (2) @(negedge clk);
    chk("mr vld", 64'(vld64), 64'd1);
    chk("mr full", 64'(rdy64), 64'd0);
    chk("mr dec", 64'(dc64), 64'd2);
    reset       = 1'b0;
    instruction = 32'hFFE1FF00;
    out_ready   = 1'b1;
    #1;
    chk("mr rdy low", 64'(rdy64), 64'd0);
    chk("mr vld low", 64'(vld64), 64'd0);
    @(negedge clk);
    chk("mr vld0", 64'(vld64), 64'd0);
    chk("mr dec0", 64'(dc64), 64'd0);
    chk("mr err0", 64'(ec64), 64'd0);
    chk("mr imm0", im64, 64'd0);
    chk("mr fmt0", 64'(fmt64), 64'd0);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mr rdy1", 64'(rdy64), 64'd1);
    chk("mr vld1", 64'(vld64), 64'd0);
    chk("mr dec1", 64'(dc64), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/imm_extract_pipe.md
IMM_EXTRACT_PIPE -- requirements
Module: imm_extract_pipe

Interface
REQ-001 The block SHALL provide parameter XLEN, default 64, immediate width; legal values 32 and 64.
REQ-002 The block SHALL provide parameter DEPTH, default 2, output-buffer entries; power of two, minimum 2.
REQ-003 The block SHALL provide port clk input 1: the single clock, rising-edge active.
REQ-004 The block SHALL provide port reset input 1: synchronous, active-low reset.
REQ-005 The block SHALL provide port in_valid input 1: an instruction is presented.
REQ-006 The block SHALL provide port in_ready output 1: the block can accept an instruction.
REQ-007 The block SHALL provide port instruction input 32: the raw RV instruction word.
REQ-008 The block SHALL provide port out_valid output 1: the head entry is valid.
REQ-009 The block SHALL provide port out_ready input 1: the consumer takes the head entry.
REQ-010 The block SHALL provide port im_data output XLEN: the sign-extended immediate.
REQ-011 The block SHALL provide port fmt output 3: the format code (0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 illegal).
REQ-012 The block SHALL provide port dec_count output 16: the number of accepted instructions.
REQ-013 The block SHALL provide port err_count output 8: the number of accepted illegal instructions.

Function
REQ-014 The block SHALL accept an instruction ("push") when in_valid=1 and in_ready=1 on a rising clk edge, where in_ready = (occupancy < DEPTH).
REQ-015 The block SHALL retire the head entry ("pop") when out_valid=1 and out_ready=1, where out_valid = (occupancy > 0).
REQ-016 The block SHALL decode each instruction in the cycle it is accepted and write {im_data, fmt} into the FIFO tail.
REQ-017 Latency SHALL be one cycle: an entry pushed into an empty buffer at edge N is presented on the outputs after edge N.
REQ-018 The block SHALL NOT bypass input to output combinationally.
REQ-019 Decode of instruction[6:0] SHALL be:
- 0000011, 0010011, 1100111 -> I;
- 0011011 -> I when XLEN=64, illegal when XLEN=32;
- 0100011 -> S;
- 1100011 -> B;
- 0110111, 0010111 -> U;
- 1101111 -> J;
- 0110011 -> R;
- 0111011 -> R when XLEN=64, illegal when XLEN=32;
- all other opcodes -> illegal.
REQ-020 Immediate construction SHALL be:
- I = sext(inst[31:20]);
- S = sext({inst[31:25], inst[11:7]});
- B = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0});
- U = sext({inst[31:12], 12'b0});
- J = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0});
- sign extension is always from inst[31] to XLEN bits.
REQ-021 For R and illegal formats, im_data SHALL be 0.
REQ-022 When full, in_ready SHALL be 0 even if out_ready=1 in that cycle; no push occurs on that edge.
REQ-023 A simultaneous push and pop when 0 < occupancy < DEPTH SHALL leave occupancy unchanged and preserve FIFO order.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 dec_count SHALL increment by 1 on every push and wrap from 0xFFFF to 0x0000.
REQ-026 err_count SHALL increment by 1 on every push decoded as illegal and saturate at 0xFF.
REQ-027 When out_valid=0, im_data and fmt SHALL hold their last value, with no X after reset.
REQ-028 The output holding state SHALL be a two-state machine, EMPTY (occupancy 0) and NONEMPTY:
- EMPTY -> NONEMPTY on a push;
- NONEMPTY -> EMPTY on a pop at occupancy 1 with no simultaneous push.

Reset
REQ-029 On any rising clk edge with reset=0, the block SHALL reset occupancy, pointers, dec_count and err_count to 0, set im_data to 0 and set fmt to 0.
REQ-030 While reset=0, in_ready SHALL be 0 and out_valid SHALL be 0.
REQ-031 Reset asserted mid-stream SHALL discard all buffered entries, and no push SHALL be counted on that edge.
REQ-032 On the first edge with reset=1 after reset, in_ready SHALL be 1.

Verification
REQ-033 XLEN=64: push 0xFFF00093 (addi x1,x0,-1) -> next cycle out_valid=1, fmt=1, im_data=0xFFFFFFFFFFFFFFFF, dec_count=1.
REQ-034 XLEN=64: push 0xFE000EE3 (beq -4), then 0x800000B7 (lui 0x80000) -> in order: fmt=3 with im_data=0xFFFFFFFFFFFFFFFC, then fmt=4 with im_data=0xFFFFFFFF80000000.
REQ-035 Illegal word: push 0xFFE1FF00 -> fmt=7, im_data=0, err_count=1; with XLEN=32, push 0x0000001B -> fmt=7.
REQ-036 Back-pressure at DEPTH=2, out_ready=0: push three back-to-back -> in_ready drops after the second push, the third is held and accepted only after a pop, and order is preserved.
REQ-037 Counters and reset:
- 65536 pushes -> dec_count wraps to 0;
- 300 illegal pushes -> err_count=0xFF;
- reset=0 with 2 entries buffered -> next cycle out_valid=0 and both counters 0.
